// File: rtl/standard_to_fwft_fifo_if.sv
// ---------------------------------------------------------------------------
// fifo_if : handshake bundle for the FWFT FIFO.
//   fifo_din    producer write data
//   fifo_wr_en  producer write request
//   fifo_rd_en  consumer pop / acknowledge of the current head
//   fifo_dout   current head word, valid while fifo_empty is low
//   fifo_full   no further writes accepted
//   fifo_empty  no valid word on fifo_dout
// master : the producer/consumer side driving requests.
// slave  : the FIFO itself.
// ---------------------------------------------------------------------------
interface fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_din;
  logic                  fifo_wr_en;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  modport master (
    output fifo_din, fifo_wr_en, fifo_rd_en,
    input  fifo_dout, fifo_full, fifo_empty
  );

  modport slave (
    input  fifo_din, fifo_wr_en, fifo_rd_en,
    output fifo_dout, fifo_full, fifo_empty
  );
endinterface

// File: rtl/standard_to_fwft_fifo.sv
// ---------------------------------------------------------------------------
// standard_to_fwft_fifo : first-word-fall-through FIFO built from a standard
// 2^ADDR_WIDTH-entry FIFO core followed by a one-entry output stage.
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    fifo_if.slave (din/wr_en in, rd_en pop in, dout/full/empty out)
// The head word is shown on fifo_dout without a read request; fifo_rd_en
// discards it and advances. Total storage is 2^ADDR_WIDTH + 1 words.
// ---------------------------------------------------------------------------
module standard_to_fwft_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  fifo_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic core_empty;
  logic core_full;
  logic wr_ok;
  logic core_rd;

  always_comb begin
    core_empty = (wptr_q == rptr_q);
    // Extra pointer MSB distinguishes a full core from an empty one.
    core_full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                 (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    wr_ok      = bus.fifo_wr_en && !core_full;
    // Refill the output stage whenever it is empty or being popped.
    core_rd    = !core_empty && (!valid_q || bus.fifo_rd_en);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    valid_d = valid_q;
    dout_d  = dout_q;

    if (wr_ok) begin
      wptr_d = wptr_q + (ADDR_WIDTH+1)'(1);
    end

    if (core_rd) begin
      rptr_d  = rptr_q + (ADDR_WIDTH+1)'(1);
      dout_d  = mem[rptr_q[ADDR_WIDTH-1:0]];
      valid_d = 1'b1;
    end else if (bus.fifo_rd_en) begin
      // Popping the last word: dout keeps its stale value, only valid drops.
      valid_d = 1'b0;
    end
  end

  // Storage array carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr_q[ADDR_WIDTH-1:0]] <= bus.fifo_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.fifo_dout  = dout_q;
  assign bus.fifo_empty = !valid_q;
  assign bus.fifo_full  = core_full;

endmodule

// File: tb/tb_standard_to_fwft_fifo.sv
// ---------------------------------------------------------------------------
// tb_standard_to_fwft_fifo : bench for the FWFT FIFO. A reference model keeps
// the stored words as a queue tagged with the edge they were written on; the
// head is visible only once it was written at an earlier edge, and the core
// holds every stored word except a visible head.
// ---------------------------------------------------------------------------
module tb_standard_to_fwft_fifo;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CORE_DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_if #(.DATA_WIDTH(DW)) bus ();

  standard_to_fwft_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
  } ent_t;

  ent_t mq[$];
  int   ecnt     = 0;
  bit   empty_m  = 1'b1;
  bit   full_m   = 1'b0;
  bit   rst_edge = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model, stepped at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      ecnt++;
      if (reset) begin
        mq.delete();
        rst_edge = 1'b1;
      end else begin
        rst_edge = 1'b0;
        if (bus.fifo_rd_en && !empty_m) void'(mq.pop_front());
        if (bus.fifo_wr_en && !full_m) mq.push_back('{bus.fifo_din, ecnt});
      end
      empty_m = (mq.size() == 0) || (mq[0].stamp == ecnt);
      full_m  = ((mq.size() - (empty_m ? 0 : 1)) == CORE_DEPTH);
    end
  end

  // Monitor: compares flags every cycle and the presented head word.
  initial begin
    forever begin
      @(negedge clk);
      chk("mon_empty", bus.fifo_empty, empty_m);
      chk("mon_full", bus.fifo_full, full_m);
      if (!empty_m && mq.size() > 0) chk("mon_dout", bus.fifo_dout, mq[0].data);
      if (rst_edge) chk("mon_rst_dout", bus.fifo_dout, 0);
    end
  end

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r);
    bus.fifo_wr_en = w;
    bus.fifo_din   = d;
    bus.fifo_rd_en = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.fifo_wr_en = 1'b0;
    bus.fifo_rd_en = 1'b0;
    bus.fifo_din   = '0;

    // Reset state
    do_reset();
    cyc(1'b0, '0, 1'b0);
    chk("rst_empty", bus.fifo_empty, 1);
    chk("rst_full", bus.fifo_full, 0);
    chk("rst_dout", bus.fifo_dout, 0);

    // Fall-through latency
    do_reset();
    cyc(1'b1, 8'd20, 1'b0);
    chk("ft_e0_empty", bus.fifo_empty, 1);
    cyc(1'b0, '0, 1'b0);
    chk("ft_e1_empty", bus.fifo_empty, 0);
    chk("ft_e1_dout", bus.fifo_dout, 20);
    repeat (3) cyc(1'b0, '0, 1'b0);
    chk("ft_stable", bus.fifo_dout, 20);

    // Ordered pops
    do_reset();
    cyc(1'b1, 8'd20, 1'b0); cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 8'd76, 1'b0); cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 8'd34, 1'b0); cyc(1'b0, '0, 1'b0);
    chk("ord_head", bus.fifo_dout, 20);
    cyc(1'b0, '0, 1'b1);
    chk("ord_pop1", bus.fifo_dout, 76);
    chk("ord_pop1_empty", bus.fifo_empty, 0);
    cyc(1'b0, '0, 1'b1);
    chk("ord_pop2", bus.fifo_dout, 34);
    chk("ord_pop2_empty", bus.fifo_empty, 0);
    cyc(1'b0, '0, 1'b1);
    chk("ord_pop3_empty", bus.fifo_empty, 1);

    // Fill to 17 words, overflow write ignored, drain in order
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, DW'(i), 1'b0);
    chk("fill_full", bus.fifo_full, 1);
    cyc(1'b1, 8'd99, 1'b0);
    chk("fill_full_hold", bus.fifo_full, 1);
    for (int i = 0; i < 17; i++) begin
      chk("drain_dout", bus.fifo_dout, i);
      chk("drain_empty", bus.fifo_empty, 0);
      cyc(1'b0, '0, 1'b1);
    end
    chk("drain_end_empty", bus.fifo_empty, 1);
    chk("drain_end_full", bus.fifo_full, 0);

    // Concurrent streaming across pointer wrap
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(100 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      chk("stream_dout", bus.fifo_dout, 100 + i);
      cyc(1'b1, DW'(103 + i), 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      chk("stream_tail", bus.fifo_dout, 140 + i);
      cyc(1'b0, '0, 1'b1);
    end
    chk("stream_end_empty", bus.fifo_empty, 1);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(10 + i), 1'b0);
    reset = 1'b1;
    cyc(1'b1, 8'd77, 1'b1);
    reset = 1'b0;
    chk("mid_rst_empty", bus.fifo_empty, 1);
    chk("mid_rst_full", bus.fifo_full, 0);
    cyc(1'b1, 8'd55, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("mid_rst_dout", bus.fifo_dout, 55);
    chk("mid_rst_vis", bus.fifo_empty, 0);

    // Randomized traffic with shifting write/read bias and rare resets
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      int wp;
      int rp;
      wp = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 60 : 95;
      rp = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 60 : 95;
      for (int i = 0; i < 200; i++) begin
        reset = ($urandom_range(0, 249) == 0);
        cyc(($urandom_range(0, 99) < wp), DW'($urandom), ($urandom_range(0, 99) < rp));
      end
    end
    reset = 1'b0;
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
